// File: rtl/regwrite_arbiter.sv
// Register-bank write-port arbiter with multicycle-unit scoreboard and hazard stall.
// Optional starvation stall is built when REGARB_STARVE_EN is defined.
module regwrite_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wb_we,
   input  logic [3:0]  wb_addr,
   input  logic [31:0] wb_data,
   input  logic        mu_req,
   input  logic [3:0]  mu_addr,
   input  logic [31:0] mu_data,
   output logic        mu_ack,
   input  logic        issue_mu,
   input  logic [3:0]  issue_addr,
   input  logic        dec_valid,
   input  logic [3:0]  dec_addr_a,
   input  logic [3:0]  dec_addr_b,
   input  logic [3:0]  dec_addr_d,
   input  logic        flush,
   output logic        we,
   output logic [3:0]  addr_d,
   output logic [31:0] data_d,
   output logic        stall,
   output logic [15:0] pending,
   output logic        err
);

   logic        wb_grant;
   logic        issue_ok;
   logic [15:0] set_vec;
   logic [15:0] clr_vec;
   logic [15:0] pending_reg;
   logic [15:0] pending_next;
   logic        err_reg;
   logic        err_next;
   logic        hz_a;
   logic        hz_b;
   logic        hz_d;
   logic        stall_hz;

   // Writes to r0 are discarded, so they never block the multicycle unit.
   assign wb_grant = wb_we && (wb_addr != 4'd0);
   assign mu_ack   = mu_req && !wb_grant;
   assign we       = wb_grant || mu_ack;

   always_comb begin
      addr_d = 4'd0;
      data_d = 32'd0;
      if (wb_grant) begin
         addr_d = wb_addr;
         data_d = wb_data;
      end else if (mu_ack) begin
         addr_d = mu_addr;
         data_d = mu_data;
      end
   end

   assign issue_ok = issue_mu && !flush && (issue_addr != 4'd0);

   generate
      for (genvar gi = 0; gi < 16; gi++) begin : g_bit
         assign set_vec[gi] = issue_ok && (issue_addr == 4'(gi));
         assign clr_vec[gi] = mu_ack && (mu_addr == 4'(gi));
         if (gi == 0) begin : g_zero
            assign pending_next[gi] = 1'b0;
         end else begin : g_live
            // A new issue outranks a retire landing on the same register.
            assign pending_next[gi] = set_vec[gi] || (pending_reg[gi] && !clr_vec[gi]);
         end
      end
   endgenerate

   assign err_next = err_reg
                   || (issue_ok && ((set_vec & pending_reg) != 16'd0))
                   || (mu_ack && ((clr_vec & pending_reg) == 16'd0));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending_reg <= 16'd0;
         err_reg     <= 1'b0;
      end else begin
         pending_reg <= pending_next;
         err_reg     <= err_next;
      end
   end

   // Read operands retiring this cycle are forwarded by the bank; a destination is not.
   assign hz_a = (dec_addr_a != 4'd0) && pending_reg[dec_addr_a]
               && !(mu_ack && (mu_addr == dec_addr_a));
   assign hz_b = (dec_addr_b != 4'd0) && pending_reg[dec_addr_b]
               && !(mu_ack && (mu_addr == dec_addr_b));
   assign hz_d = (dec_addr_d != 4'd0) && pending_reg[dec_addr_d];

   assign stall_hz = dec_valid && (hz_a || hz_b || hz_d);

`ifdef REGARB_STARVE_EN
   localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

   logic [2:0] starve_reg;
   logic [2:0] starve_next;

   always_comb begin
      starve_next = starve_reg;
      if (!mu_req || mu_ack) begin
         starve_next = 3'd0;
      end else if (starve_reg != 3'd7) begin
         starve_next = starve_reg + 3'd1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         starve_reg <= 3'd0;
      end else begin
         starve_reg <= starve_next;
      end
   end

   assign stall = stall_hz || (starve_reg >= LIMIT);
`else
   assign stall = stall_hz;
`endif

   assign pending = pending_reg;
   assign err     = err_reg;

endmodule

// File: doc/regwrite_arbiter.md
REGWRITE_ARBITER -- requirements
Module: regwrite_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, range 2-7: consecutive denied multicycle-unit cycles before the starvation stall.
REQ-002 clk  in  1  single clock; all state updates on the posedge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 wb_we, wb_addr  in  1, 4  pipeline writeback request and destination.
REQ-005 wb_data  in  32  pipeline writeback data.
REQ-006 mu_req, mu_addr  in  1, 4  multicycle-unit (divider/load) result request and destination; held stable until mu_ack.
REQ-007 mu_data  in  32  multicycle-unit result data.
REQ-008 mu_ack  out  1  grant; request and data are consumed this cycle.
REQ-009 issue_mu, issue_addr  in  1, 4  an instruction is dispatched to the multicycle unit, with its destination.
REQ-010 dec_valid, dec_addr_a, dec_addr_b, dec_addr_d  in  1, 4, 4, 4  decode-stage operand and destination registers.
REQ-011 flush  in  1  pipeline flush; issue_mu is ignored during flush.
REQ-012 we, addr_d, data_d  out  1, 4, 32  register bank write port.
REQ-013 stall  out  1  freeze fetch/decode this cycle.
REQ-014 pending  out  16  scoreboard; bit n set = register n awaits a multicycle result; bit 0 always 0.
REQ-015 err  out  1  sticky protocol error.

Function
REQ-016 Write-port select is combinational, same cycle: wb wins when wb_we=1 and wb_addr!=0; otherwise mu is granted when mu_req=1.
REQ-017 mu_ack = mu_req AND NOT (wb_we AND wb_addr!=0); we = wb grant OR mu_ack; addr_d/data_d come from the granted source, else 0.
REQ-018 wb_we with wb_addr=0 shall be dropped: we=0, mu may be granted that cycle.
REQ-019 A pending bit shall set at the posedge when issue_mu=1, flush=0 and issue_addr!=0.
REQ-020 A pending bit shall clear at the posedge when mu_ack=1 for that address.
REQ-021 Set and clear of the same bit in one cycle: set wins.
REQ-022 The stall hazard term is dec_valid AND the pending bit for any nonzero dec_addr_a, dec_addr_b or dec_addr_d.
REQ-023 A read-operand hazard (dec_addr_a or dec_addr_b) shall not stall when mu_ack=1 with mu_addr equal to that operand, because the register bank forwards data_d.
REQ-024 A destination hazard (WAW) shall stall even when mu_ack=1 for that address.
REQ-025 issue_mu to an address whose pending bit is already set shall set err.
REQ-026 mu_ack for an address whose pending bit is clear shall set err.
REQ-027 err stays set until reset; the block continues operating normally while err is set.
REQ-028 flush shall not alter pending bits, because in-flight multicycle results still retire.

Reset
REQ-029 While reset=0, and immediately without a clock edge: pending=0, err=0, starvation counter=0.
REQ-030 Combinational outputs follow their inputs during reset, except that stall uses the cleared scoreboard.
REQ-031 Reset in mid-operation shall discard all pending state; the multicycle unit is reset by the same signal.

Configuration
REQ-032 With REGARB_STARVE_EN defined, a 3-bit saturating counter shall count cycles with mu_req=1 and mu_ack=0.
REQ-033 With REGARB_STARVE_EN defined, the counter shall clear to 0 on mu_ack or when mu_req=0.
REQ-034 With REGARB_STARVE_EN defined, stall is also asserted while counter >= STARVE_LIMIT, so that pipeline bubbles free the write port.
REQ-035 Without REGARB_STARVE_EN, the counter shall not exist and stall is only the scoreboard hazard term.

Verification
REQ-036 Issue: issue_mu=1, issue_addr=5, then 3 idle cycles, then mu_req with mu_addr=5, data 0xDEADBEEF -> pending[5]=1 after the first edge; the same cycle shows mu_ack=1, we=1, addr_d=5, data_d=0xDEADBEEF; pending[5]=0 after that edge.
REQ-037 Collision: wb_we=1, wb_addr=3 and mu_req=1, mu_addr=5 for 2 cycles, then wb_we=0 -> mu_ack=0 for 2 cycles, then mu_ack=1 with addr_d=5; wb_addr=0 in place of 3 -> mu granted immediately.
REQ-038 Hazard: pending[7]=1, dec_valid=1, dec_addr_a=7 -> stall=1; the same with mu_ack on address 7 -> stall=0; with dec_addr_d=7 and mu_ack on 7 -> stall=1.
REQ-039 Errors: issue_mu to address 4 twice before retire -> err=1; mu_ack on a non-pending address 9 -> err=1; reset=0 -> err=0 and pending=0 with no clock edge.
REQ-040 Flush: issue_mu=1 with flush=1, address 6 -> pending[6] stays 0; an existing pending[2] is retained through the flush.
REQ-041 REGARB_STARVE_EN defined, STARVE_LIMIT=4: wb_we=1 on nonzero addresses continuously with mu_req held -> stall rises on the 5th cycle of waiting; stall drops the cycle after mu_ack.
